// File: rtl/fetch_stage_pkg.sv
// Shared control-unit types used by the fetch stage and branch resolution.
package fetch_stage_pkg;

    // Redirect kind requested by the decode stage.
    typedef enum logic [1:0] {
        PC4  = 2'd0,
        PCBR = 2'd1,
        PCJ  = 2'd2,
        PCJR = 2'd3
    } pcsrc_t;

    // Fetch sequencer states.
    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    // Opcode field of the HALT instruction.
    localparam logic [5:0] HALT_OP = 6'h3F;

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// Combinational control-flow target calculator, relative to the decode-stage PC+4.
module npc_calc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] npc,
    input  pcsrc_t      pcsrc,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr,
    input  logic [31:0] jraddr,
    output logic [31:0] target
);

    logic [31:0] br_off;

    // Word offset, sign-extended and scaled to bytes.
    assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

    // Select the target; PC4 is treated as a branch so a redirect always has a destination.
    always_comb begin
        target = npc + br_off;
        case (pcsrc)
            PCJ:     target = {npc[31:28], jaddr, 2'b00};
            PCJR:    target = jraddr;
            default: target = npc + br_off;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch/halt sequencer and the IF/ID latch.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  pcsrc_t      pcsrc,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr,
    input  logic [31:0] jraddr,
    output logic [31:0] instr,
    output logic [31:0] npc,
    output logic        valid,
    output logic        halted
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  npc_q, npc_d;
    logic         valid_q, valid_d;
    logic         halted_q, halted_d;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    npc_calc u_npc_calc (
        .npc    (npc_q),
        .pcsrc  (pcsrc),
        .imm16  (imm16),
        .jaddr  (jaddr),
        .jraddr (jraddr),
        .target (target)
    );

    // Next-state for the sequencer, PC and IF/ID latch; redirect beats stall beats ihit.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        npc_d    = npc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    // A word returned this cycle belongs to the squashed path.
                    pc_d    = target;
                    valid_d = 1'b0;
                end else if (stall) begin
                    // Hold everything; memory re-serves the same address later.
                    valid_d = valid_q;
                end else if (ihit) begin
                    instr_d = imemload;
                    npc_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                    if (imemload[31:26] == HALT_OP) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
            HALT: begin
                if (redirect) begin
                    // An older control transfer makes the HALT speculative.
                    pc_d     = target;
                    valid_d  = 1'b0;
                    halted_d = 1'b0;
                    state_d  = FETCH;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= FETCH;
            pc_q     <= PC_INIT;
            instr_q  <= '0;
            npc_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            npc_q    <= npc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    // Request is register-derived; reset suppresses it immediately.
    always_comb begin
        imemREN  = !RST && (state_q == FETCH);
        imemaddr = pc_q;
    end

    assign instr  = instr_q;
    assign npc    = npc_q;
    assign valid  = valid_q;
    assign halted = halted_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined MIPS core. Holds the PC, issues instruction-memory read requests, waits for `ihit`, and registers the fetched word with its PC+4 into the IF/ID latch that feeds the control unit. Applies redirects (branch, jump, jump-register) requested by the decode stage. Stops fetching at a HALT word until an older redirect supersedes it.

## Interface
- `PC_INIT`, 32'h0000_0000, PC value loaded on reset
- `CLK`  in  1  clock; all state updates on rising edge
- `RST`  in  1  synchronous, active-high reset
- `ihit`  in  1  instruction memory returns `imemload` for `imemaddr` this cycle
- `imemload`  in  32  instruction word
- `imemREN`  out  1  read request
- `imemaddr`  out  32  read address, always equal to PC
- `stall`  in  1  decode cannot accept a new instruction this cycle
- `redirect`  in  1  decode-stage instruction changes control flow this cycle
- `pcsrc`  in  2  `pcsrc_t` redirect kind: `PCBR`, `PCJ`, `PCJR` (`PC4` with `redirect` = 1 treated as `PCBR`)
- `imm16`  in  16  branch offset in words
- `jaddr`  in  26  jump target field
- `jraddr`  in  32  register value for JR
- `instr`  out  32  IF/ID instruction
- `npc`  out  32  IF/ID PC+4 of `instr`
- `valid`  out  1  IF/ID holds a real instruction
- `halted`  out  1  fetch is parked on a HALT

## Operation
- Reset (`RST` = 1 at an edge):
  - PC ← `PC_INIT`, state ← FETCH.
  - `instr` = 0, `npc` = 0, `valid` = 0, `halted` = 0.
- Outputs during and after reset:
  - While `RST` is high, `imemREN` = 0.
  - After reset, `imemREN` = (state == FETCH).
- Redirect target, computed from the current IF/ID `npc` (the decode-stage instruction):
  - `PCBR`: `npc + (sext(imm16) << 2)`, 32-bit wrap.
  - `PCJ`: `{npc[31:28], jaddr, 2'b00}`.
  - `PCJR`: `jraddr`.
- States: FETCH, HALT.
- FETCH, evaluated in this priority order:
  1. `redirect`: PC ← target, `valid` ← 0, stay in FETCH. Any `ihit` in the same cycle is discarded.
  2. `stall`: PC and latch hold. A concurrent `ihit` is dropped; the request stays asserted and memory re-serves it.
  3. `ihit`: latch loads `instr` ← `imemload`, `npc` ← PC+4, `valid` ← 1, and PC ← PC+4.
     - If `imemload[31:26]` == `HALT_OP` (6'h3F): state ← HALT, `halted` ← 1.
  4. Otherwise, if `!stall`: `valid` ← 0 (bubble). PC holds.
- HALT:
  - `imemREN` = 0 and PC is frozen.
  - Latch keeps the HALT word until decode consumes it (`!stall`), then `valid` ← 0.
  - `redirect`: PC ← target, `valid` ← 0, `halted` ← 0, state ← FETCH. The HALT was speculative.
- Simultaneous `redirect` and `stall`: `redirect` wins.
- PC+4 wraps at 2^32. There is no alignment check; bits [1:0] pass through.

## Timing
- Fetch latency: instruction visible on `instr`/`valid` the cycle after `ihit` is sampled.
- Redirect: new `imemaddr` appears the cycle after `redirect` is sampled. Exactly one bubble (`valid` = 0) follows.
- `imemaddr` and `imemREN` are derived from registers only, with no combinational path from `ihit`.
- `RST` mid-fetch abandons the outstanding request. The next cycle `imemREN` re-asserts with `imemaddr` = `PC_INIT`.

## Structure
- Add the following to the shared control-unit types package:
  - `pcsrc_t` (`PC4`, `PCBR`, `PCJ`, `PCJR`), 2 bits.
  - `fetch_state_t` (FETCH, HALT).
  - Constant `HALT_OP` = 6'h3F.
- Sub-module `npc_calc`: combinational target calculator. Inputs `npc`, `pcsrc`, `imm16`, `jaddr`, `jraddr`; output is the 32-bit target. Reused by the branch-resolution logic.
- `fetch_stage` contains the PC register, the state register, and the IF/ID latch.

## Test plan
- Reset, then `ihit` every cycle with words 0x2001_0005, 0x2002_0003:
  - `imemaddr` sequence 0x0, 0x4, 0x8.
  - `instr`/`npc` = 0x2001_0005/0x4, then 0x2002_0003/0x8.
  - `valid` = 1 from the second cycle onward.
- `ihit` delayed 3 cycles at PC 0x8:
  - `imemaddr` holds 0x8 with `imemREN` = 1.
  - `valid` = 0 until the cycle after `ihit`.
- Latch `npc` = 0x10, `redirect`, `PCBR`, `imm16` = 0xFFFE (with concurrent `ihit`):
  - Next `imemaddr` = 0x8.
  - One bubble; the concurrent `ihit` word is never latched.
- `PCJ` with `npc` = 0x1000_0004 and `jaddr` = 0x40: target 0x1000_0100. `PCJR` with `jraddr` = 0xDEAD_BEEC: target 0xDEAD_BEEC.
- `stall` held 2 cycles while `ihit` = 1:
  - `instr`, `npc`, `valid` and PC unchanged.
  - Fetch resumes the cycle `stall` drops.
- Fetch 0xFFFF_FFFF:
  - `halted` = 1 and `imemREN` = 0; PC frozen at HALT address + 4.
  - A later `redirect` `PCJ` clears `halted` and resumes fetch at the target.
  - Assert `RST` during HALT: all outputs return to their reset values the next cycle.
